// File: rtl/router_packet_rx.sv
// Serial-to-parallel packet receiver: LSB-first shift-in with start marker,
// inter-bit timeout, even-parity check and a one-entry valid/ready output stage.
module router_packet_rx #(
  parameter int PKT_W   = 13,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_vld,
  input  logic             ser_sop,
  output logic [PKT_W-1:0] packet,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow_err,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int BIT_W = $clog2(PKT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PKT_W - 1);
  localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]       to_cnt, to_cnt_nxt;
  logic [PKT_W-1:0] shreg, shreg_nxt;
  logic [PKT_W-1:0] full_pkt;
  logic             par_nxt, frm_nxt, ovf_nxt;
  logic             drop, load;

  assign busy = (state == SHIFT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    to_cnt_nxt  = to_cnt;
    shreg_nxt   = shreg;
    par_nxt     = 1'b0;
    frm_nxt     = 1'b0;
    ovf_nxt     = 1'b0;
    drop        = 1'b0;
    load        = 1'b0;
    full_pkt    = shreg;
    full_pkt[PKT_W-1] = ser_in;

    case (state)
      IDLE: begin
        if (ser_vld && ser_sop) begin
          shreg_nxt    = '0;
          shreg_nxt[0] = ser_in;
          bit_cnt_nxt  = BIT_W'(1);
          to_cnt_nxt   = '0;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_vld) begin
          to_cnt_nxt = '0;
          if (ser_sop) begin
            // Premature start marker: drop the partial packet and restart on this bit.
            frm_nxt      = 1'b1;
            drop         = 1'b1;
            shreg_nxt    = '0;
            shreg_nxt[0] = ser_in;
            bit_cnt_nxt  = BIT_W'(1);
          end else if (bit_cnt == LAST_BIT) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            if (^full_pkt) begin
              par_nxt = 1'b1;
              drop    = 1'b1;
            end else if (!pkt_valid || pkt_ready) begin
              load = 1'b1;
            end else begin
              ovf_nxt = 1'b1;
              drop    = 1'b1;
            end
          end else begin
            shreg_nxt[bit_cnt] = ser_in;
            bit_cnt_nxt        = bit_cnt + 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          // This idle cycle brings the gap to TIMEOUT cycles.
          frm_nxt     = 1'b1;
          drop        = 1'b1;
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
          to_cnt_nxt  = '0;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      shreg        <= '0;
      packet       <= '0;
      pkt_valid    <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overflow_err <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      to_cnt       <= to_cnt_nxt;
      shreg        <= shreg_nxt;
      parity_err   <= par_nxt;
      frame_err    <= frm_nxt;
      overflow_err <= ovf_nxt;
      if (load) begin
        packet    <= full_pkt;
        pkt_valid <= 1'b1;
      end else if (pkt_ready) begin
        pkt_valid <= 1'b0;
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
